// File: rtl/data_ram.sv
// data_ram: word-addressed data memory responder with configurable wait states,
// a stall back to the pipeline and registered read data with rvalid/err pulses.
module data_ram #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              commit, req, oob, wr, rd;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       mem [DEPTH];

    assign req = mem_we_i | mem_re_i;
    assign idx = mem_addr_i[ADDR_W+1:2];
    assign oob = (|mem_addr_i[31:ADDR_W+2]) || (32'(idx) >= 32'(DEPTH));
    // a commit with both we and re is a write; the read half is dropped
    assign wr  = commit & mem_we_i & ~oob;
    assign rd  = commit & mem_re_i & ~mem_we_i;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_o = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (WAIT_CYCLES == 0) begin
                    commit = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = WAIT;
                end
            end
            WAIT: if (cnt != 4'd0) begin
                stall_o = 1'b1;
                cnt_n   = cnt - 4'd1;
            end else begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata_o  <= 32'd0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rvalid_o <= rd;
            err_o    <= commit & req & oob;
            if (rd)
                rdata_o <= oob ? 32'd0 : mem[idx];
        end
    end

    // reset abandons a pending access, so it must also block the array write
    always_ff @(posedge clk) begin
        if (!rst && wr)
            mem[idx] <= mem_data_i;
    end
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: table-driven checks on a zero-wait instance plus hand-written
// multi-cycle sequences on a three-wait instance, with scoreboard queues.
module tb_data_ram;
    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic [31:0] addr0, data0, addr3, data3;
    logic        we0, re0, we3, re3;
    logic        stall0, rvalid0, err0, stall3, rvalid3, err3;
    logic [31:0] rdata0, rdata3;

    int checks = 0;
    int errors = 0;
    int due0   = 0;
    bit mon0   = 1'b0;
    vec_t q0[$];
    vec_t q3[$];
    vec_t tbl[14];

    always #5 clk = ~clk;

    data_ram #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst0), .mem_addr_i(addr0), .mem_data_i(data0),
        .mem_we_i(we0), .mem_re_i(re0), .stall_o(stall0), .rdata_o(rdata0),
        .rvalid_o(rvalid0), .err_o(err0)
    );

    data_ram #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst3), .mem_addr_i(addr3), .mem_data_i(data3),
        .mem_we_i(we3), .mem_re_i(re3), .stall_o(stall3), .rdata_o(rdata3),
        .rvalid_o(rvalid3), .err_o(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // zero-wait accesses commit at the edge after they are driven
    always @(posedge clk) due0 = q0.size();

    always @(negedge clk) begin
        vec_t e;
        if (mon0) begin
            chk("u0_stall", 32'(stall0), 32'd0);
            if (due0 > 0) begin
                e = q0.pop_front();
                due0 = 0;
                chk("u0_rvalid", 32'(rvalid0), 32'(e.rv));
                chk("u0_err", 32'(err0), 32'(e.err));
                if (e.rv)
                    chk("u0_rdata", rdata0, e.rd);
            end
        end
    end

    task automatic acc3(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                        input logic rv, input logic [31:0] rdx, input logic er);
        vec_t e;
        int n;
        q3.push_back('{we, re, a, d, rv, rdx, er});
        @(posedge clk) #1;
        we3 = we; re3 = re; addr3 = a; data3 = d;
        n = 0;
        @(negedge clk);
        while (stall3 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("u3_stall_cycles", 32'(n), 32'd3);
        @(posedge clk) #1;
        we3 = 1'b0; re3 = 1'b0;
        @(negedge clk);
        e = q3.pop_front();
        chk("u3_rvalid", 32'(rvalid3), 32'(e.rv));
        chk("u3_err", 32'(err3), 32'(e.err));
        if (e.rv)
            chk("u3_rdata", rdata3, e.rd);
        @(negedge clk);
        chk("u3_pulse_end", {30'd0, rvalid3, err3}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'h8,        32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h8,        32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        32'h11111111, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h1000,     32'h0,        1'b1, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h1000,     32'h00000BAD, 1'b0, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 32'h11111111, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h13,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h80000010, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'hFFC,      32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'hFFC,      32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};

        rst0 = 1'b1; rst3 = 1'b1;
        we0 = 1'b0; re0 = 1'b0; addr0 = '0; data0 = '0;
        we3 = 1'b0; re3 = 1'b0; addr3 = '0; data3 = '0;
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        chk("rst_u0", {rdata0[29:0], stall0, rvalid0} | 32'(err0), 32'd0);
        chk("rst_u3", {rdata3[29:0], stall3, rvalid3} | 32'(err3), 32'd0);
        chk("rst_rdata", rdata0 | rdata3, 32'd0);

        mon0 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk) #1;
            we0 = tbl[i].we; re0 = tbl[i].re; addr0 = tbl[i].addr; data0 = tbl[i].data;
            q0.push_back(tbl[i]);
        end
        @(posedge clk) #1;
        we0 = 1'b0; re0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon0 = 1'b0;
        chk("u0_drain", 32'(q0.size()), 32'd0);

        acc3(1'b1, 1'b0, 32'h4, 32'h12345678, 1'b0, 32'h0, 1'b0);
        acc3(1'b0, 1'b1, 32'h4, 32'h0, 1'b1, 32'h12345678, 1'b0);
        acc3(1'b1, 1'b0, 32'h0, 32'h77777777, 1'b0, 32'h0, 1'b0);
        acc3(1'b0, 1'b1, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
        acc3(1'b1, 1'b0, 32'h1000, 32'h0BADBAD0, 1'b0, 32'h0, 1'b1);

        // reset lands in the second cycle of a pending write
        @(posedge clk) #1;
        we3 = 1'b1; addr3 = 32'h0; data3 = 32'h55;
        @(posedge clk) #1;
        rst3 = 1'b1;
        @(posedge clk) #1;
        rst3 = 1'b0; we3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_stall", 32'(stall3), 32'd0);
            chk("rst_mid_rvalid", 32'(rvalid3), 32'd0);
        end
        acc3(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h77777777, 1'b0);
        acc3(1'b0, 1'b1, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
        acc3(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h77777777, 1'b0);
        chk("u3_drain", 32'(q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
